qspi_psram_mem: RTL and testbench
=================================

// Module: qspi_psram_mem
// PURPOSE
//  Synthesizable QSPI PSRAM slave emulator with on-chip byte memory, for FPGA checks of qspi_if without external PSRAM.
//  Successor of the fixed PSRAM model: memory depth, dummy-cycle count and burst wrap size are parametrised.
//  Adds write command, page-wrap bursts, reset-enable/reset sequence and illegal-command detection.
//  Sits directly on the qspi_if pins (sck/ce_n/sio) inside the inner-memory test wrapper.
// PARAMETERS
//  ADR_W     16  byte-address width; memory = 2**ADR_W bytes; upper received address bits ignored (alias)
//  WAIT_CYC  6   dummy sck rising edges between address and first read nibble (legal range 2..15)
//  PAGE_W    10  burst wrap boundary = 2**PAGE_W bytes (PAGE_W <= ADR_W)
// PORTS
//  clk      in   1  system clock; sck is generated by the master in this domain
//  rst_n    in   1  asynchronous active-low reset
//  sck      in   1  QSPI serial clock (idle low, mode 0)
//  ce_n     in   1  chip enable, active low
//  sio_i    in   4  data from master
//  sio_o    out  4  data to master
//  sio_oe   out  1  1 = sio_o driven (read data phase only)
//  cmd_err  out  1  one-clk pulse on unsupported command
// BEHAVIOUR
//  Reset: sio_o=0, sio_oe=0, cmd_err=0, state=IDLE, rst_en=0; memory contents not cleared.
//  Edge detect: sck_d registered; rise = sck & ~sck_d, fall = ~sck & sck_d; all sampling on rise, driving on fall.
//  States: IDLE -> CMD -> ADR -> (WAIT -> RDATA) | WDATA | IGNORE; ce_n=1 forces IDLE from any state on next clk.
//  IDLE: ce_n falling (ce_n=0) -> CMD, bit counter cleared.
//  CMD: 8 rises, sio_i[0] MSB first (single-bit SPI). Decode after 8th rise:
//   0xEB quad read -> ADR; 0x38 quad write -> ADR; 0x66 -> rst_en=1, IGNORE;
//   0x99 with rst_en=1 -> IGNORE (state cleared, rst_en=0); 0x99 without rst_en, any other -> cmd_err pulse, IGNORE.
//   Any command other than 0x66 clears rst_en.
//  ADR: 6 rises, sio_i[3:0] MS nibble first, 24-bit address; adr register keeps [ADR_W-1:0].
//  WAIT (0xEB): WAIT_CYC rises ignored; byte mem[adr] fetched into shift register during WAIT.
//  RDATA: on the fall after last dummy rise: sio_oe=1, sio_o=high nibble; next fall: low nibble; next fall: next byte high nibble.
//  WDATA (0x38): nibble pair high-then-low; byte written to mem[adr] on the rise sampling low nibble.
//  Address increment after each byte: adr[PAGE_W-1:0]+1 wraps to 0, adr[ADR_W-1:PAGE_W] held.
//  ce_n=1 mid-byte: partial write nibble discarded, no memory write; sio_oe=0 on next clk.
//  IGNORE: sio_oe=0, no memory access until ce_n=1.
//  Memory: single-port reg array, one write or one read per clk; read prefetch of next byte on high-nibble fall.
//  Simultaneous ce_n=1 and sck rise: ce_n wins, sample dropped.
//  rst_n low mid-transfer: outputs reset immediately (async), transfer lost.
// TESTING
//  0x38 adr 0x000010 data A5 3C, ce_n=1; 0xEB adr 0x000010 -> after 6 dummies sio_o 0xA,0x5,0x3,0xC, sio_oe=1.
//  0x38 adr 0x0003FF data 11 22 (PAGE_W=10) -> read 0x0003FF=11, 0x000000=22, 0x000400 unchanged.
//  0x38 adr 0x010020 data 77 (ADR_W=16) -> 0xEB adr 0x000020 returns 0x77.
//  Command 0x12 -> cmd_err one-clk pulse, sio_oe stays 0, next 0xEB works normally.
//  0x38 adr 0x40, one nibble then ce_n=1 -> mem[0x40] unchanged; 0x66 then 0x99 -> no cmd_err; lone 0x99 -> cmd_err.
//  rst_n low during RDATA -> sio_oe=0, sio_o=0 same cycle; after release, read of prior data intact.

Source files
------------

// File: rtl/qspi_psram_mem_if.sv
// QSPI pin bundle between the qspi_if master and the PSRAM emulator.
interface qspi_psram_mem_if;
    logic       sck;
    logic       ce_n;
    logic [3:0] sio_i;
    logic [3:0] sio_o;
    logic       sio_oe;
    logic       cmd_err;

    modport master (
        output sck, ce_n, sio_i,
        input  sio_o, sio_oe, cmd_err
    );

    modport slave (
        input  sck, ce_n, sio_i,
        output sio_o, sio_oe, cmd_err
    );
endinterface

// File: rtl/qspi_psram_mem.sv
// QSPI PSRAM slave emulator: quad read (0xEB), quad write (0x38), reset-enable/reset
// (0x66/0x99), page-wrapping bursts and an on-chip byte memory of 2**ADR_W bytes.
module qspi_psram_mem #(
    parameter int unsigned ADR_W    = 16,
    parameter int unsigned WAIT_CYC = 6,
    parameter int unsigned PAGE_W   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    qspi_psram_mem_if.slave  bus
);

    localparam int unsigned     DEPTH     = 2 ** ADR_W;
    localparam logic [ADR_W-1:0] PAGE_MASK = ADR_W'((64'd1 << PAGE_W) - 64'd1);
    localparam logic [3:0]      WAIT_LAST = 4'(WAIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADR,
        S_WAIT,
        S_RDATA,
        S_WDATA,
        S_IGNORE
    } state_t;

    state_t           state;
    logic             sck_d;
    logic             rise;
    logic             fall;
    logic [3:0]       cnt;
    logic [6:0]       cmd_sh;
    logic [7:0]       cmd_byte;
    logic             is_read;
    logic             rst_en;
    logic             nib;
    logic [3:0]       wr_hi;
    logic [3:0]       rd_lo;
    logic [ADR_W-1:0] adr;
    logic [ADR_W-1:0] adr_inc;
    logic             mem_we;
    logic [7:0]       rd_q;
    logic [7:0]       mem [DEPTH];

    // sck edge detect and decode helpers
    assign rise     = bus.sck & ~sck_d;
    assign fall     = ~bus.sck & sck_d;
    assign cmd_byte = {cmd_sh, bus.sio_i[0]};
    assign adr_inc  = (adr & ~PAGE_MASK) | ((adr + ADR_W'(1)) & PAGE_MASK);
    assign mem_we   = (state == S_WDATA) && rise && nib && !bus.ce_n;

    // Single-port byte memory: write on low-nibble rise, otherwise keep prefetching mem[adr]
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[adr] <= {wr_hi, bus.sio_i};
        end else begin
            rd_q <= mem[adr];
        end
    end

    // Protocol FSM with registered pin outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sck_d       <= 1'b0;
            cnt         <= 4'd0;
            cmd_sh      <= 7'd0;
            is_read     <= 1'b0;
            rst_en      <= 1'b0;
            nib         <= 1'b0;
            wr_hi       <= 4'd0;
            rd_lo       <= 4'd0;
            adr         <= '0;
            bus.sio_o   <= 4'd0;
            bus.sio_oe  <= 1'b0;
            bus.cmd_err <= 1'b0;
        end else begin
            sck_d       <= bus.sck;
            bus.cmd_err <= 1'b0;
            if (bus.ce_n) begin
                // deselect wins over any coincident sck edge; partial nibbles are dropped
                state      <= S_IDLE;
                cnt        <= 4'd0;
                nib        <= 1'b0;
                bus.sio_oe <= 1'b0;
                bus.sio_o  <= 4'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_CMD;
                        cnt   <= 4'd0;
                    end
                    S_CMD: if (rise) begin
                        cmd_sh <= cmd_byte[6:0];
                        cnt    <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt <= 4'd0;
                            case (cmd_byte)
                                8'hEB: begin
                                    is_read <= 1'b1;
                                    rst_en  <= 1'b0;
                                    state   <= S_ADR;
                                end
                                8'h38: begin
                                    is_read <= 1'b0;
                                    rst_en  <= 1'b0;
                                    state   <= S_ADR;
                                end
                                8'h66: begin
                                    rst_en <= 1'b1;
                                    state  <= S_IGNORE;
                                end
                                8'h99: begin
                                    bus.cmd_err <= ~rst_en;
                                    rst_en      <= 1'b0;
                                    state       <= S_IGNORE;
                                end
                                default: begin
                                    bus.cmd_err <= 1'b1;
                                    rst_en      <= 1'b0;
                                    state       <= S_IGNORE;
                                end
                            endcase
                        end
                    end
                    S_ADR: if (rise) begin
                        // upper address bits beyond ADR_W shift out and alias
                        adr <= {adr[ADR_W-5:0], bus.sio_i};
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd5) begin
                            cnt   <= 4'd0;
                            nib   <= 1'b0;
                            state <= is_read ? S_WAIT : S_WDATA;
                        end
                    end
                    S_WAIT: if (rise) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == WAIT_LAST) begin
                            cnt   <= 4'd0;
                            nib   <= 1'b0;
                            state <= S_RDATA;
                        end
                    end
                    S_RDATA: if (fall) begin
                        if (!nib) begin
                            // high nibble out, low nibble held, next byte prefetched
                            bus.sio_oe <= 1'b1;
                            bus.sio_o  <= rd_q[7:4];
                            rd_lo      <= rd_q[3:0];
                            adr        <= adr_inc;
                            nib        <= 1'b1;
                        end else begin
                            bus.sio_o <= rd_lo;
                            nib       <= 1'b0;
                        end
                    end
                    S_WDATA: if (rise) begin
                        if (!nib) begin
                            wr_hi <= bus.sio_i;
                            nib   <= 1'b1;
                        end else begin
                            adr <= adr_inc;
                            nib <= 1'b0;
                        end
                    end
                    S_IGNORE: begin
                        bus.sio_oe <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qspi_psram_mem.sv
// Self-checking bench for qspi_psram_mem: random and directed QSPI transfers against a byte-map model.
module tb_qspi_psram_mem;

    localparam int ADR_W    = 16;
    localparam int WAIT_CYC = 6;
    localparam int PAGE_W   = 10;
    localparam int DEPTH    = 1 << ADR_W;
    localparam int PAGE     = 1 << PAGE_W;

    logic clk;
    logic rst_n;
    qspi_psram_mem_if bus();

    qspi_psram_mem #(
        .ADR_W   (ADR_W),
        .WAIT_CYC(WAIT_CYC),
        .PAGE_W  (PAGE_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int err_cnt;
    int err_wide;
    logic err_prev;
    logic [7:0] model [int];
    logic [7:0] byte_q [$];

    // count cmd_err pulses and any pulse longer than one clk
    always @(posedge clk) begin
        if (bus.cmd_err) err_cnt <= err_cnt + 1;
        if (bus.cmd_err && err_prev) err_wide <= err_wide + 1;
        err_prev <= bus.cmd_err;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic int wrap_next(input int a);
        return (a / PAGE) * PAGE + ((a % PAGE) + 1) % PAGE;
    endfunction

    task automatic sck_beat(input logic [3:0] d, output logic [3:0] q, output logic oe);
        @(negedge clk);
        bus.sio_i = d;
        @(negedge clk);
        @(negedge clk);
        bus.sck = 1'b1;
        @(negedge clk);
        @(negedge clk);
        q = bus.sio_o;
        oe = bus.sio_oe;
        bus.sck = 1'b0;
    endtask

    task automatic cs_begin();
        @(negedge clk);
        bus.ce_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cs_end();
        @(negedge clk);
        bus.ce_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        logic [3:0] q;
        logic oe;
        for (int i = 7; i >= 0; i--) sck_beat({3'b000, b[i]}, q, oe);
    endtask

    task automatic send_adr(input logic [23:0] a);
        logic [3:0] q;
        logic oe;
        for (int i = 5; i >= 0; i--) sck_beat(a[i*4 +: 4], q, oe);
    endtask

    // quad write of byte_q starting at a; model follows the page-wrap rule
    task automatic do_write(input logic [23:0] a);
        logic [3:0] q;
        logic oe;
        int ma;
        cs_begin();
        send_cmd(8'h38);
        send_adr(a);
        ma = int'(a) % DEPTH;
        foreach (byte_q[k]) begin
            sck_beat(byte_q[k][7:4], q, oe);
            sck_beat(byte_q[k][3:0], q, oe);
            model[ma] = byte_q[k];
            ma = wrap_next(ma);
        end
        cs_end();
    endtask

    // quad read of n bytes from a, every nibble compared with the model
    task automatic do_read(input string name, input logic [23:0] a, input int n);
        logic [3:0] q;
        logic oe;
        logic [7:0] exp;
        int ma;
        cs_begin();
        send_cmd(8'hEB);
        send_adr(a);
        for (int i = 0; i < WAIT_CYC; i++) sck_beat(4'h0, q, oe);
        ma = int'(a) % DEPTH;
        for (int k = 0; k < n; k++) begin
            exp = model.exists(ma) ? model[ma] : 8'h00;
            sck_beat(4'h0, q, oe);
            checks++;
            if (oe !== 1'b1) begin
                errors++;
                $display("FAIL %s oe byte%0d: got %b want 1", name, k, oe);
            end
            if (model.exists(ma)) begin
                checks++;
                if (q !== exp[7:4]) begin
                    errors++;
                    $display("FAIL %s hi @%h: got %h want %h", name, ma, q, exp[7:4]);
                end
            end
            sck_beat(4'h0, q, oe);
            if (model.exists(ma)) begin
                checks++;
                if (q !== exp[3:0]) begin
                    errors++;
                    $display("FAIL %s lo @%h: got %h want %h", name, ma, q, exp[3:0]);
                end
            end
            ma = wrap_next(ma);
        end
        cs_end();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.ce_n = 1'b1;
        bus.sck = 1'b0;
        bus.sio_i = 4'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.sio_oe !== 1'b0 || bus.sio_o !== 4'h0 || bus.cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: oe=%b o=%h err=%b want 0 0 0", bus.sio_oe, bus.sio_o, bus.cmd_err);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.sio_oe !== 1'b0 || bus.sio_o !== 4'h0 || bus.cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: oe=%b o=%h err=%b want 0 0 0", bus.sio_oe, bus.sio_o, bus.cmd_err);
        end
    endtask

    task automatic test_basic();
        byte_q = '{8'hA5, 8'h3C};
        do_write(24'h000010);
        do_read("basic", 24'h000010, 2);
    endtask

    task automatic test_page_wrap();
        byte_q = '{8'h5E};
        do_write(24'h000400);
        byte_q = '{8'h11, 8'h22};
        do_write(24'h0003FF);
        do_read("wrap_3ff", 24'h0003FF, 1);
        do_read("wrap_000", 24'h000000, 1);
        do_read("wrap_400", 24'h000400, 1);
        do_read("wrap_burst", 24'h0003FF, 2);
    endtask

    task automatic test_alias();
        byte_q = '{8'h77};
        do_write(24'h010020);
        do_read("alias", 24'h000020, 1);
    endtask

    task automatic test_bad_cmd();
        logic [3:0] q;
        logic oe;
        int e0;
        e0 = err_cnt;
        cs_begin();
        send_cmd(8'h12);
        for (int i = 0; i < 4; i++) begin
            sck_beat(4'h0, q, oe);
            checks++;
            if (oe !== 1'b0) begin
                errors++;
                $display("FAIL bad_cmd_oe beat%0d: got %b want 0", i, oe);
            end
        end
        cs_end();
        checks++;
        if (err_cnt !== e0 + 1) begin
            errors++;
            $display("FAIL bad_cmd_err: got %0d pulses want 1", err_cnt - e0);
        end
        checks++;
        if (err_wide !== 0) begin
            errors++;
            $display("FAIL bad_cmd_width: got %0d long pulses want 0", err_wide);
        end
        do_read("after_bad", 24'h000010, 2);
    endtask

    task automatic test_partial_write();
        logic [3:0] q;
        logic oe;
        byte_q = '{8'h9D};
        do_write(24'h000040);
        cs_begin();
        send_cmd(8'h38);
        send_adr(24'h000040);
        sck_beat(4'hF, q, oe);
        cs_end();
        do_read("partial", 24'h000040, 1);
    endtask

    task automatic test_reset_seq();
        int e0;
        e0 = err_cnt;
        cs_begin();
        send_cmd(8'h66);
        cs_end();
        cs_begin();
        send_cmd(8'h99);
        cs_end();
        checks++;
        if (err_cnt !== e0) begin
            errors++;
            $display("FAIL rst_seq: got %0d pulses want 0", err_cnt - e0);
        end
        cs_begin();
        send_cmd(8'h99);
        cs_end();
        checks++;
        if (err_cnt !== e0 + 1) begin
            errors++;
            $display("FAIL lone_99: got %0d pulses want 1", err_cnt - e0);
        end
        cs_begin();
        send_cmd(8'h66);
        cs_end();
        cs_begin();
        send_cmd(8'hEB);
        cs_end();
        cs_begin();
        send_cmd(8'h99);
        cs_end();
        checks++;
        if (err_cnt !== e0 + 2) begin
            errors++;
            $display("FAIL rst_en_cleared: got %0d pulses want 2", err_cnt - e0);
        end
    endtask

    task automatic test_random();
        logic [23:0] a;
        int n;
        for (int it = 0; it < 6; it++) begin
            a = 24'($urandom_range(0, 32'h00FF_FFFF));
            n = $urandom_range(1, 4);
            byte_q = {};
            for (int k = 0; k < n; k++) byte_q.push_back(8'($urandom));
            do_write(a);
            do_read("random", a, n);
        end
    endtask

    task automatic test_rst_mid_read();
        logic [3:0] q;
        logic oe;
        cs_begin();
        send_cmd(8'hEB);
        send_adr(24'h000010);
        for (int i = 0; i < WAIT_CYC; i++) sck_beat(4'h0, q, oe);
        sck_beat(4'h0, q, oe);
        checks++;
        if (oe !== 1'b1 || q !== 4'hA) begin
            errors++;
            $display("FAIL pre_rst_read: oe=%b o=%h want 1 a", oe, q);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.sio_oe !== 1'b0 || bus.sio_o !== 4'h0) begin
            errors++;
            $display("FAIL rst_mid_read: oe=%b o=%h want 0 0", bus.sio_oe, bus.sio_o);
        end
        bus.ce_n = 1'b1;
        bus.sck = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_read("after_rst", 24'h000010, 2);
        do_read("after_rst_wrap", 24'h0003FF, 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        err_cnt = 0;
        err_wide = 0;
        err_prev = 1'b0;
        test_reset();
        test_basic();
        test_page_wrap();
        test_alias();
        test_bad_cmd();
        test_partial_write();
        test_reset_seq();
        test_random();
        test_rst_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
